xadac_dcache_splitter: RTL
==========================

Name: xadac_dcache_splitter

Overview:
Parametrised successor to the fixed-width XADAC wide-to-narrow data path. Accepts one wide vector load/store request at a time and splits it into NarrowWidth-sized dcache beats. Supports up to MaxOutstanding pipelined read beats, optionally skips beats whose byte enables are all zero, and reassembles read data into one wide response. Sits between the XADAC vector unit and the core's external dcache port.

Parameters:
AddrWidth, 64, byte address width
NarrowWidth, 64, dcache data width in bits (XLEN)
WideWidth, 256, vector data width in bits; Beats = WideWidth/NarrowWidth, a power of two >= 2
MaxOutstanding, 2, maximum read beats granted but not yet answered (1..Beats)
SkipEmptyBeats, 1, 1 = beats with all-zero byte enables are not issued

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  wide request valid
req_ready  out  1  wide request accepted
req_we  in  1  1 = store, 0 = load
req_addr  in  AddrWidth  wide base address; low log2(WideWidth/8) bits ignored and treated as 0
req_wdata  in  WideWidth  store data
req_be  in  WideWidth/8  byte enables
rsp_valid  out  1  wide completion valid (loads and stores)
rsp_ready  in  1  completion accepted
rsp_rdata  out  WideWidth  load data; 0 for stores
mem_req_valid  out  1  narrow beat request
mem_req_ready  in  1  narrow beat grant
mem_req_we  out  1  beat is a store
mem_req_addr  out  AddrWidth  base + i*NarrowWidth/8
mem_req_wdata  out  NarrowWidth  slice i of req_wdata
mem_req_be  out  NarrowWidth/8  slice i of req_be
mem_rsp_valid  in  1  read beat data valid, in grant order
mem_rsp_rdata  in  NarrowWidth  read beat data
protocol_err  out  1  sticky: mem_rsp_valid seen while no read outstanding

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE, all outputs 0 except req_ready=1; outstanding count, beat index and index FIFO cleared; protocol_err cleared. Reset mid-transfer abandons the request; memory side must be reset together.
- Request captured into registers on req_valid&&req_ready; inputs need not be held afterwards.
- IDLE: req_ready=1. On accept -> ISSUE, beat index = first beat to issue. If SkipEmptyBeats and req_be==0 -> RESP directly (rdata 0).
- ISSUE: mem_req_valid=1 for current beat i; fields stable until mem_req_ready. For loads, mem_req_valid is held low while outstanding==MaxOutstanding. On grant, advance to next beat i+1..Beats-1, skipping empty beats when SkipEmptyBeats=1; skipped load slices read 0. On grant of the last beat: store -> RESP; load -> DRAIN (or RESP in the same cycle as the final response arrives).
- Granted load beat indices are pushed into an in-order FIFO of depth MaxOutstanding. On mem_rsp_valid, the popped index selects the rsp_rdata slice to write.
- Outstanding counter: +1 on load grant, -1 on mem_rsp_valid, unchanged when both occur in the same cycle; it never exceeds MaxOutstanding.
- DRAIN: wait until outstanding==0, then -> RESP.
- RESP: rsp_valid=1, rsp_rdata stable; on rsp_ready -> IDLE. req_ready=0 in every state except IDLE, so there is no back-to-back overlap.
- Latency: first mem_req_valid asserts the cycle after accept. Store rsp_valid asserts the cycle after the last grant. Load rsp_valid asserts the cycle after the last mem_rsp_valid.
- mem_rsp_valid with outstanding==0: data dropped, protocol_err=1 until reset.
- Stores never wait for mem_rsp; a store with MaxOutstanding=1 still issues back-to-back.

Test Plan:
- Store, WideWidth=256, be=all 1s, addr 0x1000, mem_req_ready=1 -> 4 beats at 0x1000/08/10/18 with matching wdata slices on consecutive cycles; rsp_valid the following cycle; rsp_rdata=0.
- Load, all beats, memory returns 0x11..,0x22..,0x33..,0x44.. one cycle after each grant -> rsp_rdata = {0x44..,0x33..,0x22..,0x11..}; outstanding never exceeds 2.
- Load, MaxOutstanding=2, memory withholds responses -> exactly 2 grants, then mem_req_valid=0 until the first response; the 3rd beat issues in the cycle after it.
- SkipEmptyBeats=1, be=0x00FF_0000 (beat 2 only) -> single mem beat at base+0x10; other slices of rsp_rdata are 0. be=0 -> no mem beat, rsp_valid the cycle after accept.
- mem_req_ready low 3 cycles on beat 1 -> addr/wdata/be stable throughout; rsp_ready held low 2 cycles -> rsp_valid and rsp_rdata stable, req_ready=0.
- Spurious mem_rsp_valid in IDLE -> protocol_err=1 and stays set; rstn=0 mid-ISSUE -> next cycle IDLE, req_ready=1, protocol_err=0.

Source files
------------

// File: rtl/xadac_dcache_splitter.sv
// ============================================================================
// Module : xadac_dcache_splitter
// Splits one wide vector load/store into narrow dcache beats; reassembles reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xadac_dcache_splitter #(
  parameter int AddrWidth      = 64,
  parameter int NarrowWidth    = 64,
  parameter int WideWidth      = 256,
  parameter int MaxOutstanding = 2,
  parameter int SkipEmptyBeats = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [AddrWidth-1:0]     req_addr,
  input  logic [WideWidth-1:0]     req_wdata,
  input  logic [WideWidth/8-1:0]   req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WideWidth-1:0]     rsp_rdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [AddrWidth-1:0]     mem_req_addr,
  output logic [NarrowWidth-1:0]   mem_req_wdata,
  output logic [NarrowWidth/8-1:0] mem_req_be,
  input  logic                     mem_rsp_valid,
  input  logic [NarrowWidth-1:0]   mem_rsp_rdata,
  output logic                     protocol_err
);

  localparam int BEATS = WideWidth / NarrowWidth;
  localparam int NB    = NarrowWidth / 8;
  localparam int WB    = WideWidth / 8;
  localparam int IDXW  = $clog2(BEATS);
  localparam int OFFW  = $clog2(WB);
  localparam int NOFFW = $clog2(NB);
  localparam int CNTW  = $clog2(MaxOutstanding + 1);
  localparam int PTRW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CNTW-1:0] C_MAX_CNT  = CNTW'(MaxOutstanding);
  localparam logic [CNTW-1:0] C_ONE_CNT  = CNTW'(1);
  localparam logic [PTRW-1:0] C_LAST_PTR = PTRW'(MaxOutstanding - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_we;
  logic [AddrWidth-1:0]   r_addr;
  logic [WideWidth-1:0]   r_wdata;
  logic [WideWidth-1:0]   r_rdata;
  logic [WB-1:0]          r_be;
  logic [IDXW-1:0]        r_idx;
  logic [CNTW-1:0]        r_cnt;
  logic [IDXW-1:0]        r_fifo [MaxOutstanding];
  logic [PTRW-1:0]        r_wptr;
  logic [PTRW-1:0]        r_rptr;
  logic                   r_perr;

  logic                   w_first_found;
  logic [IDXW-1:0]        w_first_idx;
  logic                   w_next_found;
  logic [IDXW-1:0]        w_next_idx;
  logic                   w_grant;
  logic                   w_lgrant;
  logic                   w_rsp_hit;
  logic                   w_rsp_spur;
  logic [IDXW-1:0]        w_rd_idx;
  logic                   w_unused_addr_lo;

  // Lowest issuable beat of the incoming request, and the next one after r_idx.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (SkipEmptyBeats == 0 || |req_be[b*NB +: NB]) begin
        w_first_found = 1'b1;
        w_first_idx   = IDXW'(b);
      end
      if (IDXW'(b) > r_idx && (SkipEmptyBeats == 0 || |r_be[b*NB +: NB])) begin
        w_next_found = 1'b1;
        w_next_idx   = IDXW'(b);
      end
    end
  end

  assign w_unused_addr_lo = ^req_addr[OFFW-1:0];

  assign mem_req_valid = (r_state == S_ISSUE) && (r_we || (r_cnt != C_MAX_CNT));
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr + AddrWidth'({r_idx, {NOFFW{1'b0}}});
  assign mem_req_wdata = r_wdata[r_idx*NarrowWidth +: NarrowWidth];
  assign mem_req_be    = r_be[r_idx*NB +: NB];
  assign req_ready     = (r_state == S_IDLE);
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_rdata     = r_rdata;
  assign protocol_err  = r_perr;

  assign w_grant    = mem_req_valid && mem_req_ready;
  assign w_lgrant   = w_grant && !r_we;
  assign w_rsp_hit  = mem_rsp_valid && (r_cnt != '0);
  assign w_rsp_spur = mem_rsp_valid && (r_cnt == '0);
  assign w_rd_idx   = r_fifo[r_rptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_be    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_perr  <= 1'b0;
      for (int k = 0; k < MaxOutstanding; k++) begin
        r_fifo[k] <= '0;
      end
    end else begin
      if (w_rsp_spur) begin
        r_perr <= 1'b1;
      end

      // Index FIFO remembers which slice each outstanding read fills.
      if (w_lgrant) begin
        r_fifo[r_wptr] <= r_idx;
        r_wptr         <= (r_wptr == C_LAST_PTR) ? '0 : r_wptr + 1'b1;
      end
      if (w_rsp_hit) begin
        r_rdata[w_rd_idx*NarrowWidth +: NarrowWidth] <= mem_rsp_rdata;
        r_rptr <= (r_rptr == C_LAST_PTR) ? '0 : r_rptr + 1'b1;
      end

      if (w_lgrant && !w_rsp_hit) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_lgrant && w_rsp_hit) begin
        r_cnt <= r_cnt - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= {req_addr[AddrWidth-1:OFFW], {OFFW{1'b0}}};
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_rdata <= '0;
            r_idx   <= w_first_idx;
            r_state <= w_first_found ? S_ISSUE : S_RESP;
          end
        end
        S_ISSUE: begin
          if (w_grant) begin
            if (w_next_found) begin
              r_idx <= w_next_idx;
            end else if (r_we) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Leave on the final response itself so rsp_valid follows it directly.
          if ((r_cnt == '0) || (w_rsp_hit && r_cnt == C_ONE_CNT)) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
